// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian (1-2-1 / 2-4-2 / 1-2-1, /16 rounded) window filter.
// Paces window reads, filters in two stages, writes one pixel per window.
module gauss3x3_filter #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stall,
   input  logic [7:0] pixelr1,
   input  logic [7:0] pixelr2,
   input  logic [7:0] pixelr3,
   input  logic [7:0] pixelr4,
   input  logic [7:0] pixelr5,
   input  logic [7:0] pixelr6,
   input  logic [7:0] pixelr7,
   input  logic [7:0] pixelr8,
   input  logic [7:0] pixelr9,
   output logic       rd,
   output logic       wr,
   output logic [7:0] pixelw,
   output logic       busy,
   output logic       done
);

   localparam logic [12:0] LAST_WIN = 13'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   state_t      state;
   logic [12:0] win_cnt;
   logic        v0, v1, v2;
   logic [9:0]  a, b, c;
   logic [11:0] s;
   logic [12:0] s_rnd;

   function automatic logic [9:0] row_sum(
      input logic [7:0] x,
      input logic [7:0] y,
      input logic [7:0] z
   );
      return {2'b00, x} + {1'b0, y, 1'b0} + {2'b00, z};
   endfunction

   assign rd    = (state == READ) & ~stall;
   assign busy  = (state != IDLE);
   assign wr    = v2;
   assign s     = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   assign s_rnd = {1'b0, s} + 13'd8;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         win_cnt <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  win_cnt <= '0;
               end
            end
            READ: begin
               if (rd) begin
                  win_cnt <= win_cnt + 13'd1;
                  if (win_cnt == LAST_WIN)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               // v2 still holds the final write this cycle
               if (!v0 && !v1) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0     <= 1'b0;
         v1     <= 1'b0;
         v2     <= 1'b0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         pixelw <= '0;
      end else begin
         v0 <= rd;
         v1 <= v0;
         v2 <= v1;
         if (v0) begin
            a <= row_sum(pixelr1, pixelr2, pixelr3);
            b <= row_sum(pixelr4, pixelr5, pixelr6);
            c <= row_sum(pixelr7, pixelr8, pixelr9);
         end
         pixelw <= v1 ? s_rnd[11:4] : 8'd0;
      end
   end

endmodule

// File: tb/tb_gauss3x3_filter.sv
// Directed bench for gauss3x3_filter: kernel values, latency,
// frame counts, stall gaps, start handling and mid-frame reset.
module tb_gauss3x3_filter;

   localparam int NPIX = 256 * 32;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stall;
   logic [7:0] mp [9];
   logic       rd, wr, busy, done;
   logic [7:0] pixelw;

   gauss3x3_filter #(.IMG_W(256), .IMG_H(32)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .pixelr1(mp[0]), .pixelr2(mp[1]), .pixelr3(mp[2]),
      .pixelr4(mp[3]), .pixelr5(mp[4]), .pixelr6(mp[5]),
      .pixelr7(mp[6]), .pixelr8(mp[7]), .pixelr9(mp[8]),
      .rd(rd), .wr(wr), .pixelw(pixelw), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // window k of a frame uses pattern k%5
   function automatic logic [7:0] pat(input int k, input int i);
      case (k)
         0: return 8'd100;
         1: return (i == 4) ? 8'd255 : 8'd0;
         2: return (i == 0) ? 8'd255 : 8'd0;
         3: return 8'd255;
         default: return (i == 1 || i == 3 || i == 5 || i == 7) ? 8'd1 : 8'd0;
      endcase
   endfunction

   function automatic int expv(input int k);
      case (k)
         0: return 100;
         1: return 64;
         2: return 16;
         3: return 255;
         default: return 1;
      endcase
   endfunction

   logic clr_req;
   int   mem_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) mp[i] <= 8'd0;
         mem_idx <= 0;
      end else if (clr_req) begin
         for (int i = 0; i < 9; i++) mp[i] <= 8'd0;
         mem_idx <= 0;
      end else if (rd) begin
         for (int i = 0; i < 9; i++) mp[i] <= pat(mem_idx % 5, i);
         mem_idx <= mem_idx + 1;
      end else begin
         for (int i = 0; i < 9; i++) mp[i] <= 8'd0;
      end
   end

   int cyc = 0;
   int rd_cnt, rd_first, rd_last, rd_rise, rd_fall;
   int wr_cnt, wr_first, wr_last, wr_rise, wr_fall;
   int done_cnt, done_cyc, busy_at_done, pix_err;
   int first5 [5];
   logic prev_rd = 1'b0;
   logic prev_wr = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (clr_req) begin
         rd_cnt = 0; rd_first = 0; rd_last = 0; rd_rise = 0; rd_fall = 0;
         wr_cnt = 0; wr_first = 0; wr_last = 0; wr_rise = 0; wr_fall = 0;
         done_cnt = 0; done_cyc = 0; busy_at_done = 0; pix_err = 0;
         for (int i = 0; i < 5; i++) first5[i] = -1;
      end else begin
         if (rd) begin
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
            if (!prev_rd) rd_rise++;
         end else if (prev_rd && rd_fall == 0) begin
            rd_fall = cyc;
         end
         if (wr) begin
            if (wr_cnt == 0) wr_first = cyc;
            if (wr_cnt < 5) first5[wr_cnt] = int'(pixelw);
            if (int'(pixelw) != expv(wr_cnt % 5)) pix_err++;
            wr_last = cyc;
            wr_cnt++;
            if (!prev_wr) wr_rise++;
         end else if (prev_wr && wr_fall == 0) begin
            wr_fall = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
         end
      end
      prev_rd = rd;
      prev_wr = wr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 20000) begin
         tick();
         k++;
      end
      check(tag, int'(done), 1);
   endtask

   task automatic wait_reads(input string tag, input int n);
      int k;
      k = 0;
      while (rd_cnt < n && k < 20000) begin
         tick();
         k++;
      end
      check(tag, int'(rd_cnt >= n), 1);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      stall   = 1'b0;
      clr_req = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("idle_ctl", int'({rd, wr, busy, done}), 0);
      check("idle_pix", int'(pixelw), 0);

      // frame A: no stall
      clear_stats();
      stall = 1'b1;
      pulse_start();
      stall = 1'b0;
      wait_done("a_done_seen");
      check("a_busy_in_done", int'(busy), 0);
      repeat (3) tick();
      check("a_rd_cnt", rd_cnt, NPIX);
      check("a_rd_run", rd_rise, 1);
      check("a_rd_span", rd_last - rd_first + 1, NPIX);
      check("a_wr_cnt", wr_cnt, NPIX);
      check("a_wr_run", wr_rise, 1);
      check("a_latency", wr_first - rd_first, 3);
      check("a_done_after_wr", done_cyc - wr_last, 1);
      check("a_busy_at_done", busy_at_done, 0);
      check("a_done_width", done_cnt, 1);
      check("a_pix_err", pix_err, 0);
      check("k_all100", first5[0], 100);
      check("k_center255", first5[1], 64);
      check("k_corner255", first5[2], 16);
      check("k_all255", first5[3], 255);
      check("k_round", first5[4], 1);

      // frame B: stall gap and ignored start
      clear_stats();
      pulse_start();
      wait_reads("b_poll500", 500);
      pulse_start();
      wait_reads("b_poll2000", 2000);
      stall = 1'b1;
      repeat (5) tick();
      stall = 1'b0;
      wait_done("b_done_seen");
      check("b_rd_cnt", rd_cnt, NPIX);
      check("b_wr_cnt", wr_cnt, NPIX);
      check("b_rd_runs", rd_rise, 2);
      check("b_rd_gap", rd_last - rd_first + 1 - rd_cnt, 5);
      check("b_wr_gap", wr_last - wr_first + 1 - wr_cnt, 5);
      check("b_gap_shift", wr_fall - rd_fall, 3);
      check("b_latency", wr_first - rd_first, 3);
      check("b_pix_err", pix_err, 0);

      // frame C: start in the done cycle, then reset mid-frame
      start   = 1'b1;
      clr_req = 1'b1;
      tick();
      start   = 1'b0;
      clr_req = 1'b0;
      check("c_restart_rd", int'(rd), 1);
      check("c_restart_busy", int'(busy), 1);
      wait_reads("c_poll1000", 1000);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_ctl", int'({rd, wr, busy, done}), 0);
      check("rst_async_pix", int'(pixelw), 0);
      repeat (2) tick();
      rst = 1'b0;
      clear_stats();
      repeat (10) tick();
      check("rst_no_rd", rd_cnt, 0);
      check("rst_no_wr", wr_cnt, 0);

      // frame D: full frame after reset
      pulse_start();
      wait_done("d_done_seen");
      repeat (2) tick();
      check("d_rd_cnt", rd_cnt, NPIX);
      check("d_wr_cnt", wr_cnt, NPIX);
      check("d_latency", wr_first - rd_first, 3);
      check("d_pix_err", pix_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gauss3x3_filter.md
# gauss3x3_filter

Downstream processing stage for the 3x3 window memory. It paces window reads by driving `rd`, applies a 3x3 Gaussian kernel (1 2 1 / 2 4 2 / 1 2 1, divided by 16 with rounding) to the nine returned pixels, and returns one filtered pixel per window to the memory's write port via `wr`/`pixelw`. One frame is IMG_W x IMG_H output pixels; start, stall and completion are handshaked with the system controller.

## Interface

- IMG_W, 256, output pixels per row (window columns)
- IMG_H, 32, output rows per frame
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame start request, sampled in IDLE only
- stall  in  1  suppress window reads this cycle
- pixelr1..pixelr9  in  8 each  window pixels from the memory, row-major (1..3 top row, 4..6 middle, 7..9 bottom)
- rd  out  1  window read request to the memory
- wr  out  1  filtered-pixel write strobe to the memory
- pixelw  out  8  filtered pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse

## Operation

- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ when `start`=1 at a clock edge.
  - READ -> DRAIN on the edge where the last window is read. The last window is the one with rd=1 and win_cnt = IMG_W*IMG_H-1.
  - DRAIN -> IDLE once the pipeline is empty. The transition produces the `done` pulse.
- `rd` is combinational: (state==READ) & ~stall.
- win_cnt is 13 bits, clears on entering READ, and increments on each cycle with rd=1.
- Memory contract: pixels requested in cycle t are valid in cycle t+1. While rd=0, the memory drives zeros; those zeros must never reach `wr`.
- Valid tracking is a 3-bit shift register:
  - v0 = rd delayed one cycle (inputs valid).
  - v1 marks stage-1 results.
  - v2 drives `wr`.
- Stage 1 (captured when v0=1), each sum 10 bits:
  - a = p1 + 2*p2 + p3
  - b = p4 + 2*p5 + p6
  - c = p7 + 2*p8 + p9
- Stage 2 (captured when v1=1):
  - s = a + 2*b + c, 12 bits, maximum 4080.
  - pixelw = (s + 8) >> 4, 13-bit intermediate, maximum result 255, so no saturation is needed.
- When v1=0, the next cycle's wr=0 and pixelw=0.
- busy = (state != IDLE).
- `start` while busy is ignored, with no queuing.
- `stall` in IDLE or DRAIN has no effect. `stall` in READ only opens gaps; the frame still issues exactly IMG_W*IMG_H reads and writes.
- `rst` asserted mid-frame: immediate return to IDLE, all outputs and valid bits clear, and in-flight results are discarded. Realigning the memory's address counters is handled by system reset, not by this block.

## Timing

- Reset values:
  - rd=0, wr=0, pixelw=0, busy=0, done=0
  - state=IDLE, win_cnt=0, v0..v2=0, stage registers 0
- start=1 sampled at edge E -> READ from the cycle after E. rd=1 in that cycle if stall=0.
- Latency: rd=1 in cycle t -> wr=1 with the corresponding pixelw in cycle t+3. Exactly one wr per rd, in order.
- Without stall: rd is high for IMG_W*IMG_H consecutive cycles, followed by IMG_W*IMG_H consecutive wr cycles starting 3 cycles later.
- Last read in cycle T:
  - DRAIN occupies T+1..T+3.
  - Final wr in T+3.
  - done=1 and busy=0 in T+4.
  - done is 1 for exactly one cycle.
- A new start is accepted in the done cycle (T+4) at the earliest.

## Test plan

- Reset: assert rst asynchronously mid-cycle -> rd, wr, pixelw, busy and done are 0 immediately. After release, outputs stay 0 until start.
- Kernel values, single window each:
  - all nine inputs 100 -> pixelw=100
  - p5=255, others 0 -> 64
  - p1=255, others 0 -> 16
  - all 255 -> 255
  - p2=p4=p6=p8=1, others 0 -> 1 (s=8, rounding)
- Latency and frame count, start with stall=0 (IMG_W=256, IMG_H=32):
  - rd high for exactly 8192 consecutive cycles.
  - First wr 3 cycles after the first rd.
  - 8192 wr pulses in total.
  - done one cycle after the last wr; busy drops in the same cycle.
- Stall: stall high for 5 cycles mid-frame -> rd low for those 5 cycles, a 5-cycle wr gap 3 cycles later, zeros from the memory are never written, and the totals are still 8192/8192.
- Start while busy is ignored: no restart and no change to win_cnt. Start in the done cycle begins a new frame on the next cycle.
- Reset mid-frame after 1000 reads -> IDLE, no further wr. After release, a fresh start yields a full 8192-pixel frame.
